// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one two-half-add full-add slice per clock
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d, ps_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, h1, g1, s, g2, c_n, last;
  assign h1 = a_q[0] ^ b_q[0];
  assign g1 = a_q[0] & b_q[0];
  assign s = h1 ^ c_q;
  assign g2 = h1 & c_q;
  assign c_n = g1 | g2;
  assign ps_n = {s, ps_q[WIDTH-1:1]};
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    cnt_d = cnt_q;
    ps_d = ps_q;
    sum_d = sum_q;
    cout_d = cout_q;
    if (state_q == IDLE && start) begin
      a_d = a;
      b_d = b;
      c_d = 1'b0;
      cnt_d = '0;
      ps_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      c_d = c_n;
      cnt_d = cnt_q + CW'(1);
      ps_d = ps_n;
      state_d = last ? DONE : RUN;
      sum_d = last ? ps_n : sum_q;
      cout_d = last ? c_n : cout_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      ps_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      ps_q <= ps_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH 8 and 4
module tb_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic c;
  } vec_t;
  vec_t v[9];
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle8;
    for (int i = 0; i < 40 && (busy8 || done8); i++) @(negedge clk);
  endtask
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, output int bc, output logic ok);
    idle8();
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        ok = 1'b1;
        break;
      end
      if (busy8) bc++;
      @(negedge clk);
    end
  endtask
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, output int bc, output logic ok);
    for (int i = 0; i < 40 && (busy4 || done4); i++) @(negedge clk);
    a4 = av;
    b4 = bv;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done4) begin
        ok = 1'b1;
        break;
      end
      if (busy4) bc++;
      @(negedge clk);
    end
  endtask
  initial begin
    int bc, dn, bz, bad;
    logic ok;
    int dts[$];
    logic [7:0] ra, rb;
    v[0] = '{8'h05, 8'h03, 8'h08, 1'b0};
    v[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    v[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    v[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    v[4] = '{8'h10, 8'h20, 8'h30, 1'b0};
    v[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
    v[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    v[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    v[8] = '{8'hC3, 8'h5A, 8'h1D, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset8", {busy8, done8, cout8, sum8}, 11'h0);
    chk("reset4", {busy4, done4, cout4, sum4}, 7'h0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      run8(v[i].a, v[i].b, bc, ok);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_busy", i), bc, 8);
      chk($sformatf("vec%0d_sum", i), sum8, v[i].s);
      chk($sformatf("vec%0d_cout", i), cout8, v[i].c);
    end
    idle8();
    for (int t = 0; t < 32; t++) begin
      a8 = busy8 ? 8'hFF : 8'h10;
      b8 = busy8 ? 8'hFF : 8'h20;
      start8 = 1'b1;
      if (done8) begin
        dts.push_back(t);
        chk("hold_sum", {cout8, sum8}, 9'h030);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("hold_count", dts.size(), 3);
    for (int i = 1; i < dts.size(); i++) chk("hold_spacing", dts[i] - dts[i-1], 10);
    run8(8'h05, 8'h03, bc, ok);
    chk("pre_ign_sum", sum8, 8'h08);
    idle8();
    a8 = 8'hAA;
    b8 = 8'h11;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dn = 0;
    bad = 0;
    for (int i = 0; i < 40 && dn == 0; i++) begin
      start8 = (i == 3);
      a8 = (i == 3) ? 8'h01 : 8'hAA;
      b8 = (i == 3) ? 8'h01 : 8'h11;
      if (done8) dn++;
      else if (sum8 !== 8'h08) bad++;
      if (dn == 0) @(negedge clk);
    end
    chk("ign_hold_sum", bad, 0);
    chk("ign_done", dn, 1);
    chk("ign_sum", {cout8, sum8}, 9'h0BB);
    start8 = 1'b1;
    a8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    dn = 0;
    bz = 0;
    for (int i = 0; i < 12; i++) begin
      dn += int'(done8);
      bz += int'(busy8);
      @(negedge clk);
    end
    chk("ign_extra_done", dn, 0);
    chk("ign_extra_busy", bz, 0);
    run8(8'h05, 8'h03, bc, ok);
    chk("pre_rst_sum", sum8, 8'h08);
    idle8();
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy8, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_state", {busy8, done8, cout8, sum8}, 11'h0);
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      dn += int'(done8);
      @(negedge clk);
    end
    chk("midrst_no_done", dn, 0);
    run4(4'hF, 4'hF, bc, ok);
    chk("w4_ff_done", ok, 1);
    chk("w4_ff_busy", bc, 4);
    chk("w4_ff_res", {cout4, sum4}, 5'h1E);
    run4(4'h9, 4'h8, bc, ok);
    chk("w4_98_res", {cout4, sum4}, 5'h11);
    run4(4'h3, 4'h4, bc, ok);
    chk("w4_34_res", {cout4, sum4}, 5'h07);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, bc, ok);
      chk("rand", {ok, cout8, sum8}, {1'b1, 9'(ra) + 9'(rb)});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB first, one bit per clock.
- Each bit slice is a 1-bit full-add built from two XOR/AND half-add slices plus an OR.
- A registered carry links the slices across cycles.
- Sits directly downstream of the combinational half-add stage. Used where area matters more than latency; the controlling block pulses start and waits for done.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge only
- b  input  WIDTH  operand B; sampled on the accepting edge only
- busy  output  1  high while an addition is in progress (RUN state)
- done  output  1  one-cycle pulse: sum/cout just updated
- sum  output  WIDTH  registered result (a+b) mod 2^WIDTH
- cout  output  1  registered carry out of the MSB

Behaviour:
- Reset, on the rising clk edge with rst_n=0:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand shift regs, carry reg, bit counter and partial-sum reg all cleared.
  - rst_n low mid-RUN aborts the operation; no done pulse.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are registered decodes, with no combinational path from inputs.
- IDLE:
  - start=1 at an edge: latch a and b into shift regs, carry=0, count=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, one bit per edge:
  - Compute the slice from shift-reg bit 0 of A (x) and of B (y), plus carry c:
    - h1 = x^y, g1 = x&y
    - s = h1^c, g2 = h1&c
    - next carry = g1|g2
  - Shift s into partial-sum MSB, partial-sum shifts right.
  - Operand regs shift right; count increments.
  - At the edge where count==WIDTH-1: partial-sum bit completes, go to DONE.
    - On the same edge, load sum with the final partial-sum (including this bit) and cout with the next carry.
- DONE: lasts exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency:
  - start sampled at edge E0.
  - busy is high for cycles E0..E0+WIDTH (WIDTH cycles).
  - done is high in the single cycle after edge E0+WIDTH.
  - Earliest next accept is edge E0+WIDTH+2, so throughput is one add per WIDTH+2 cycles.
- sum/cout change only on the RUN→DONE edge (or reset). They hold the previous result throughout RUN and IDLE.
- start while busy or in DONE: ignored. The operands in flight are unaffected, and no request is queued.
- a/b changing during RUN: no effect.
- Arithmetic:
  - {cout,sum} == a+b as unsigned WIDTH+1 bits.
  - Wrap-around: sum is mod 2^WIDTH; overflow is reported only via cout.
- No X propagation: every register has a defined reset value, and counter width is clog2(WIDTH).

Test Plan:
- Reset, then WIDTH=8, a=8'h05, b=8'h03, start pulse -> busy high 8 cycles; done pulse after 8 cycles; sum=8'h08, cout=0.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1; the carry reg is cleared between ops.
- Hold start high continuously with a=8'h10, b=8'h20 -> accepts every WIDTH+2 cycles; each done yields sum=8'h30. Changing a/b mid-RUN does not alter the result.
- After a completed op (sum=8'h08), start a new op and assert rst_n=0 at RUN bit 4 -> next edge: busy=0, done=0, sum=0, cout=0; no done pulse follows.
- Start pulse during RUN and during DONE -> ignored; exactly one done per accepted start. sum holds 8'h08 throughout the second op until its RUN→DONE edge.
- WIDTH=4 instance: a=4'hF, b=4'hF -> sum=4'hE, cout=1 after 4 busy cycles. Random regression of 1000 ops checks {cout,sum}==a+b.
